// File: rtl/alu_pkg.sv
// -----------------------------------------------------------------------------
// alu_pkg
// Shared definitions for the sequential ALU blocks.
//   ALU_WIDTH   : default operand width for the sequential arithmetic units
//   alu_state_e : common IDLE / CALC / DONE operation state encoding
//   cnt_width() : iteration counter width able to hold 0..w
// -----------------------------------------------------------------------------
package alu_pkg;

    localparam int ALU_WIDTH = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } alu_state_e;

    // One extra bit over log2 so the counter can represent the full count w.
    function automatic int cnt_width(input int w);
        return $clog2(w) + 1;
    endfunction

endpackage : alu_pkg

// File: rtl/booth_step.sv
// -----------------------------------------------------------------------------
// booth_step
// One radix-2 Booth iteration, purely combinational.
//   acc_i  [WIDTH:0]   : partial-product accumulator A (one guard bit)
//   q_i    [WIDTH-1:0] : multiplier shift register Q
//   qm1_i              : Booth history bit Q_-1
//   m_i    [WIDTH:0]   : sign-extended multiplicand M
//   acc_o / q_o / qm1_o: {A,Q,Q_-1} after add/subtract and arithmetic shift
// -----------------------------------------------------------------------------
module booth_step
    import alu_pkg::*;
#(
    parameter int WIDTH = ALU_WIDTH
) (
    input  logic [WIDTH:0]   acc_i,
    input  logic [WIDTH-1:0] q_i,
    input  logic             qm1_i,
    input  logic [WIDTH:0]   m_i,
    output logic [WIDTH:0]   acc_o,
    output logic [WIDTH-1:0] q_o,
    output logic             qm1_o
);

    logic [WIDTH:0] sum;

    always_comb begin
        sum = acc_i;
        case ({q_i[0], qm1_i})
            2'b01:   sum = acc_i + m_i;
            2'b10:   sum = acc_i - m_i;
            default: sum = acc_i;
        endcase
    end

    // Arithmetic right shift of the concatenation {sum, Q, Q_-1}.
    assign acc_o = {sum[WIDTH], sum[WIDTH:1]};
    assign q_o   = {sum[0], q_i[WIDTH-1:1]};
    assign qm1_o = q_i[0];

endmodule : booth_step

// File: rtl/booth_mul.sv
// -----------------------------------------------------------------------------
// booth_mul
// Sequential radix-2 Booth multiplier, signed WIDTH x WIDTH -> 2*WIDTH.
//   clk          : clock, all state on rising edge
//   rst_n        : synchronous active-low reset
//   start        : request an operation, only looked at while busy = 0
//   multiplicand : signed operand M
//   multiplier   : signed operand Q
//   product      : last result, held until the next operation completes
//   busy         : operation in progress (state != IDLE)
//   done         : one-cycle strobe, product valid from this cycle on
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | waiting for start; operands latched on the accepting edge
// CALC  | one Booth iteration per cycle, WIDTH cycles
// DONE  | product loaded on entry; returns to IDLE next cycle
// -----------------------------------------------------------------------------
module booth_mul
    import alu_pkg::*;
#(
    parameter int WIDTH = ALU_WIDTH
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [WIDTH-1:0]   multiplicand,
    input  logic [WIDTH-1:0]   multiplier,
    output logic [2*WIDTH-1:0] product,
    output logic               busy,
    output logic               done
);

    localparam int CW = cnt_width(WIDTH);

    alu_state_e         state_q;
    logic [WIDTH:0]     acc_q;
    logic [WIDTH:0]     m_q;
    logic [WIDTH-1:0]   q_q;
    logic               qm1_q;
    logic [CW-1:0]      cnt_q;
    logic [2*WIDTH-1:0] product_q;
    logic               busy_q;
    logic               done_q;

    logic [WIDTH:0]     acc_d;
    logic [WIDTH-1:0]   q_d;
    logic               qm1_d;

    booth_step #(
        .WIDTH (WIDTH)
    ) u_step (
        .acc_i (acc_q),
        .q_i   (q_q),
        .qm1_i (qm1_q),
        .m_i   (m_q),
        .acc_o (acc_d),
        .q_o   (q_d),
        .qm1_o (qm1_d)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            acc_q     <= '0;
            m_q       <= '0;
            q_q       <= '0;
            qm1_q     <= 1'b0;
            cnt_q     <= '0;
            product_q <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        state_q <= CALC;
                        busy_q  <= 1'b1;
                        // Guard bit keeps A +/- M exact for M = -2^(WIDTH-1).
                        m_q     <= {multiplicand[WIDTH-1], multiplicand};
                        q_q     <= multiplier;
                        acc_q   <= '0;
                        qm1_q   <= 1'b0;
                        cnt_q   <= '0;
                    end
                end
                CALC: begin
                    acc_q <= acc_d;
                    q_q   <= q_d;
                    qm1_q <= qm1_d;
                    if (cnt_q == CW'(WIDTH - 1)) begin
                        state_q   <= DONE;
                        product_q <= {acc_d[WIDTH-1:0], q_d};
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                    // Strobe is a registered decode of DONE, so it lands
                    // WIDTH+1 edges after the accepting edge, in the same
                    // cycle a back-to-back start can be taken.
                    done_q  <= 1'b1;
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign product = product_q;
    assign busy    = busy_q;
    assign done    = done_q;

endmodule : booth_mul

// File: doc/booth_mul.md
BOOTH_MUL -- requirements
Module: booth_mul

Interface
REQ-001 Parameter: WIDTH, 16, operand width in bits; product is 2*WIDTH bits.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, synchronous, active-low.
REQ-004 start  input  1  request a multiplication; sampled only while busy=0.
REQ-005 multiplicand  input  WIDTH  signed two's-complement operand M.
REQ-006 multiplier  input  WIDTH  signed two's-complement operand Q.
REQ-007 product  output  2*WIDTH  signed result register; holds last result.
REQ-008 busy  output  1  high while an operation is in progress (state != IDLE).
REQ-009 done  output  1  one-cycle pulse; product valid from this cycle on.

Function
REQ-010 The block SHALL implement sequential radix-2 Booth multiplication: signed(multiplicand) * signed(multiplier), exact over the full 2*WIDTH range.
REQ-011 States SHALL be IDLE, CALC, DONE; IDLE->CALC on start=1; CALC->DONE after WIDTH iterations; DONE->IDLE unconditionally next cycle.
REQ-012 On the edge accepting start, the block SHALL latch M (sign-extended to WIDTH+1), Q, clear accumulator A (WIDTH+1 bits), clear Q_-1 and the iteration counter.
REQ-013 Each CALC cycle, based on {Q[0],Q_-1}: 01 -> A=A+M; 10 -> A=A-M; 00/11 -> A unchanged; then arithmetic right shift of {A,Q,Q_-1} by one.
REQ-014 A SHALL be WIDTH+1 bits so that M = -2^(WIDTH-1) cannot overflow the add/subtract.
REQ-015 Counter SHALL be $clog2(WIDTH)+1 bits; CALC lasts exactly WIDTH cycles.
REQ-016 On entry to DONE, product SHALL load {A[WIDTH-1:0],Q}; done=1 for exactly that one cycle.
REQ-017 Latency: start sampled at edge k -> done high after edge k+WIDTH+1 (17 for WIDTH=16); next start accepted at edge k+WIDTH+2 earliest.
REQ-018 busy SHALL be 1 in CALC and DONE, 0 in IDLE; start while busy=1 SHALL be ignored with no effect on the current operation.
REQ-019 Operand input changes after acceptance SHALL have no effect on the running result.
REQ-020 product SHALL be unchanged except on entry to DONE; it holds through IDLE and the next CALC.
REQ-021 start held high continuously SHALL launch back-to-back operations, one per WIDTH+2 cycles, each using operands present at its accept edge.

Reset
REQ-022 With rst_n=0 at a rising edge: state=IDLE, product=0, busy=0, done=0, A/Q/Q_-1/M/counter=0.
REQ-023 Reset asserted mid-operation SHALL abort without asserting done and without updating product beyond clearing it; start is ignored while rst_n=0.
REQ-024 First start after rst_n returns high SHALL be accepted normally.

Structure
REQ-025 Shared package alu_pkg SHALL hold the state enum (IDLE, CALC, DONE) and the default WIDTH constant, reused by other ALU sequential blocks.
REQ-026 One combinational sub-module booth_step SHALL compute one iteration (add/sub select plus arithmetic shift); booth_mul holds FSM, counter and registers.

Verification
REQ-027 0x14B4 * 0x0043 (5300*67) -> product 0x00056B1C, done exactly 17 cycles after start edge.
REQ-028 0xFFFF * 0xFFFF (-1*-1) -> 0x00000001; 0x0007 * 0xFFFD (7*-3) -> 0xFFFFFFEB.
REQ-029 0x8000 * 0x8000 -> 0x40000000; 0x8000 * 0x0001 -> 0xFFFF8000 (overflow-corner check).
REQ-030 Start pulsed and operands changed at cycle 5 of CALC -> ignored; first result correct, single done pulse.
REQ-031 rst_n low at cycle 8 of CALC -> no done, product=0, busy=0; next start 0x0003*0x0004 -> 0x0000000C.
REQ-032 Random signed operands (>=10k, start held high back-to-back) compared against reference model product; done period exactly 18 cycles.
